// File: rtl/ram_cr_pkg.sv
// Shared constants, types and helpers for the 8x8 column-write / row-read transpose buffer.
package ram_cr_pkg;

  localparam int unsigned NLANE = 8;

  typedef logic bank_idx_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } bank_state_t;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned byte_w);
    return lane * byte_w;
  endfunction

  // Normalise the byte mask to "1 = write this lane".
  function automatic logic [NLANE-1:0] be_to_wen(input logic [NLANE-1:0] be, input bit act_low);
    return act_low ? ~be : be;
  endfunction

endpackage

// File: rtl/ram_cr_bank.sv
// One 8x8 byte matrix: a whole column is written per cycle, a whole row is read combinationally.
module ram_cr_bank
  import ram_cr_pkg::*;
#(
  parameter int unsigned BYTE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [2:0]                col,
  input  logic [NLANE-1:0]          wen,
  input  logic [NLANE*BYTE_W-1:0]   wdata,
  input  logic [2:0]                row,
  output logic [NLANE*BYTE_W-1:0]   rdata
);

  logic [BYTE_W-1:0] mem [NLANE][NLANE];

  // Column c lands in lane (7-c) of every row; input lane (7-r) feeds row r.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NLANE; r++) begin
        for (int unsigned l = 0; l < NLANE; l++) begin
          mem[r][l] <= '0;
        end
      end
    end else if (we) begin
      for (int unsigned r = 0; r < NLANE; r++) begin
        if (wen[NLANE-1-r]) begin
          mem[r][~col] <= wdata[lane_lo(NLANE-1-r, BYTE_W) +: BYTE_W];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned l = 0; l < NLANE; l++) begin
      rdata[lane_lo(l, BYTE_W) +: BYTE_W] = mem[row][l];
    end
  end

endmodule

// File: rtl/ram_cr_buf.sv
// Column-write / row-read 8x8 byte transpose buffer with valid/ready on both sides.
// Define RAM_CR_PINGPONG_EN for two banks (fill overlaps drain); default is a single bank.
module ram_cr_buf
  import ram_cr_pkg::*;
#(
  parameter int unsigned BYTE_W     = 8,
  parameter bit          BE_ACT_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NLANE-1:0]          in_be,
  input  logic [NLANE*BYTE_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NLANE*BYTE_W-1:0]   out_data,
  output logic [2:0]                out_row,
  output logic                      out_last,
  output logic                      busy
);

  localparam int unsigned W = NLANE * BYTE_W;

`ifdef RAM_CR_PINGPONG_EN
  localparam int unsigned NBANK = 2;
`else
  localparam int unsigned NBANK = 1;
`endif

  bank_state_t      state [2];
  logic [1:0]       full;
  logic [2:0]       col_cnt;
  logic [2:0]       row_cnt;
  bank_idx_t        wsel;
  bank_idx_t        rsel;
  logic             wr_fire;
  logic             rd_fire;
  logic [NLANE-1:0] wen;
  logic [W-1:0]     rd_data [2];

  always_comb begin
    full = '0;
    for (int unsigned b = 0; b < 2; b++) begin
      full[b] = (state[b] == DRAIN);
    end
  end

  assign in_ready  = ~full[wsel];
  assign out_valid = full[rsel];
  assign wr_fire   = in_valid & in_ready & ~clr;
  assign rd_fire   = out_valid & out_ready & ~clr;
  assign wen       = be_to_wen(in_be, BE_ACT_LOW);

  assign out_data  = rd_data[rsel];
  assign out_row   = row_cnt;
  assign out_last  = out_valid & (row_cnt == 3'd7);
  assign busy      = (|full) | (col_cnt != '0);

  // The unused second slot reads as zero so the select muxes stay uniform.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NBANK) begin : g_inst
      ram_cr_bank #(
        .BYTE_W(BYTE_W)
      ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire && (wsel == bank_idx_t'(b))),
        .col   (col_cnt),
        .wen   (wen),
        .wdata (in_data),
        .row   (row_cnt),
        .rdata (rd_data[b])
      );
    end else begin : g_none
      assign rd_data[b] = '0;
    end
  end

  // A fill and a drain completing together always target different banks.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= '{default: FILL};
      col_cnt <= '0;
      row_cnt <= '0;
      wsel    <= '0;
      rsel    <= '0;
    end else begin
      if (wr_fire) begin
        if (col_cnt == 3'd7) begin
          state[wsel] <= DRAIN;
          col_cnt     <= '0;
          if (NBANK == 2) wsel <= ~wsel;
        end else begin
          col_cnt <= col_cnt + 3'd1;
        end
      end
      if (rd_fire) begin
        if (row_cnt == 3'd7) begin
          state[rsel] <= FILL;
          row_cnt     <= '0;
          if (NBANK == 2) rsel <= ~rsel;
        end else begin
          row_cnt <= row_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_cr_buf.sv
// Directed self-checking bench for ram_cr_buf (single-bank or ping-pong build).
module tb_ram_cr_buf;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0]  in_be;
  logic [63:0] in_data, out_data;
  logic [2:0]  out_row;
  int          total = 0;
  int          bad = 0;

  ram_cr_buf #(.BYTE_W(8), .BE_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_be(in_be), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Column c of frame f: input lane k carries f*64 + c*8 + k.
  function automatic logic [63:0] frame_col(input int f, input int c);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(f*64 + c*8 + k);
    return v;
  endfunction

  // Row r gets input lane (7-r) of column c placed in lane (7-c).
  function automatic logic [63:0] exp_row(input int f, input int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[(7-c)*8 +: 8] = 8'(f*64 + c*8 + (7-r));
    return v;
  endfunction

  task automatic push_col(input logic [63:0] d, input logic [7:0] be);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_be = be;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL push_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_row(output logic [63:0] d, output logic [2:0] r, output logic l);
    int n;
    n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL pop_timeout out_valid=%0b required 1", out_valid);
    end
    d = out_data; r = out_row; l = out_last;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic push_frame(input int f);
    for (int c = 0; c < 8; c++) push_col(frame_col(f, c), 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out_row !== 3'd0) begin bad++; $display("FAIL reset_out_row got=%0d want=0", out_row); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b want=0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
  endtask

  task automatic test_transpose();
    logic [63:0] d; logic [2:0] r; logic l; logic [7:0] cv;
    for (int c = 0; c < 8; c++) begin
      cv = 8'(c);
      push_col({8{cv}}, 8'h00);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t1_latency out_valid got=%0b want=1", out_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%0b want=1", busy); end
    for (int i = 0; i < 8; i++) begin
      pop_row(d, r, l);
      total++; if (d !== 64'h0001020304050607) begin bad++; $display("FAIL t1_row%0d_data got=%h want=0001020304050607", i, d); end
      total++; if (r !== 3'(i)) begin bad++; $display("FAIL t1_row%0d_index got=%0d want=%0d", i, r, i); end
      total++; if (l !== (i == 7)) begin bad++; $display("FAIL t1_row%0d_last got=%0b want=%0b", i, l, (i == 7)); end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_idle_busy got=%0b want=0", busy); end
  endtask

  task automatic test_mask();
    logic [63:0] d, want; logic [2:0] r; logic l;
    for (int c = 0; c < 8; c++) push_col({8{8'hFF}}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      pop_row(d, r, l);
      total++; if (d !== {8{8'hFF}}) begin bad++; $display("FAIL t2_fill_row%0d got=%h want=ffffffffffffffff", i, d); end
    end
    // be=F0 (active low): input lanes 7..4 masked -> rows 0..3 keep 0xFF, rows 4..7 become 0.
    for (int c = 0; c < 8; c++) push_col(64'h0, 8'hF0);
    for (int i = 0; i < 8; i++) begin
      pop_row(d, r, l);
      want = (i < 4) ? {8{8'hFF}} : 64'h0;
      total++; if (d !== want) begin bad++; $display("FAIL t2_mask_row%0d got=%h want=%h", i, d, want); end
    end
  endtask

  task automatic test_stall();
    logic [63:0] d; logic [2:0] r; logic l; logic exp_ir;
`ifdef RAM_CR_PINGPONG_EN
    exp_ir = 1'b1;
`else
    exp_ir = 1'b0;
`endif
    push_frame(1);
    for (int i = 0; i < 3; i++) begin
      pop_row(d, r, l);
      total++; if (d !== exp_row(1, i)) begin bad++; $display("FAIL t3_pre_row%0d got=%h want=%h", i, d, exp_row(1, i)); end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t3_hold%0d_valid got=%0b want=1", k, out_valid); end
      total++; if (out_row !== 3'd3) begin bad++; $display("FAIL t3_hold%0d_row got=%0d want=3", k, out_row); end
      total++; if (out_data !== exp_row(1, 3)) begin bad++; $display("FAIL t3_hold%0d_data got=%h want=%h", k, out_data, exp_row(1, 3)); end
      total++; if (in_ready !== exp_ir) begin bad++; $display("FAIL t3_hold%0d_in_ready got=%0b want=%0b", k, in_ready, exp_ir); end
    end
    for (int i = 3; i < 8; i++) begin
      pop_row(d, r, l);
      total++; if (r !== 3'(i)) begin bad++; $display("FAIL t3_post_row%0d_index got=%0d want=%0d", i, r, i); end
      total++; if (d !== exp_row(1, i)) begin bad++; $display("FAIL t3_post_row%0d got=%h want=%h", i, d, exp_row(1, i)); end
    end
  endtask

  task automatic test_clr();
    logic [63:0] d; logic [2:0] r; logic l;
    for (int c = 0; c < 4; c++) push_col({8{8'hAA}}, 8'h00);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_busy got=%0b want=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t5_in_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t5_out_valid got=%0b want=0", out_valid); end
    // A column offered together with clr must be dropped.
    in_valid = 1'b1; clr = 1'b1; in_data = {8{8'h55}}; in_be = 8'h00;
    @(posedge clk); #1 in_valid = 1'b0; clr = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_clr_drop_busy got=%0b want=0", busy); end
    push_frame(2);
    for (int i = 0; i < 8; i++) begin
      pop_row(d, r, l);
      total++; if (d !== exp_row(2, i)) begin bad++; $display("FAIL t5_row%0d got=%h want=%h", i, d, exp_row(2, i)); end
    end
  endtask

  task automatic test_back_to_back();
    int in_cnt, out_cnt, first_out, last_out, last_in, want_span, want_last_in;
    logic in_fire, out_fire;
`ifdef RAM_CR_PINGPONG_EN
    want_span = 23; want_last_in = 23;
`else
    want_span = 39; want_last_in = 39;
`endif
    in_cnt = 0; out_cnt = 0; first_out = -1; last_out = -1; last_in = -1;
    for (int cyc = 0; cyc < 100 && out_cnt < 24; cyc++) begin
      @(negedge clk);
      in_valid = (in_cnt < 24);
      in_data = frame_col(4 + in_cnt / 8, in_cnt % 8);
      in_be = 8'h00;
      out_ready = 1'b1;
      in_fire = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        total++;
        if (out_data !== exp_row(4 + out_cnt / 8, out_cnt % 8)) begin
          bad++; $display("FAIL t4_out%0d got=%h want=%h", out_cnt, out_data, exp_row(4 + out_cnt / 8, out_cnt % 8));
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        out_cnt++;
      end
      if (in_fire) begin
        last_in = cyc;
        in_cnt++;
      end
      @(posedge clk);
    end
    #1 in_valid = 1'b0; out_ready = 1'b0;
    total++; if (in_cnt !== 24) begin bad++; $display("FAIL t4_in_count got=%0d want=24", in_cnt); end
    total++; if (out_cnt !== 24) begin bad++; $display("FAIL t4_out_count got=%0d want=24", out_cnt); end
    total++; if (first_out !== 8) begin bad++; $display("FAIL t4_first_out got=%0d want=8", first_out); end
    total++; if (last_out - first_out !== want_span) begin bad++; $display("FAIL t4_out_span got=%0d want=%0d", last_out - first_out, want_span); end
    total++; if (last_in !== want_last_in) begin bad++; $display("FAIL t4_last_in got=%0d want=%0d", last_in, want_last_in); end
  endtask

  task automatic test_rst_mid();
    logic [63:0] d; logic [2:0] r; logic l;
    push_frame(3);
    for (int i = 0; i < 5; i++) pop_row(d, r, l);
    @(negedge clk);
    total++; if (out_row !== 3'd5) begin bad++; $display("FAIL t6_pre_row got=%0d want=5", out_row); end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t6_out_valid got=%0b want=0", out_valid); end
    total++; if (out_row !== 3'd0) begin bad++; $display("FAIL t6_out_row got=%0d want=0", out_row); end
    total++; if (out_data !== 64'h0) begin bad++; $display("FAIL t6_out_data got=%h want=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t6_in_ready got=%0b want=1", in_ready); end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_be = 8'hFF; in_data = '0;
    test_reset();
    test_transpose();
    test_mask();
    test_stall();
    test_clr();
    test_back_to_back();
    test_rst_mid();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
